// File: rtl/lut_seq_match.sv
// Serial sync-word / pattern detector with a run-time programmable code table.
// A WIDTH-bit shift window is compared against NUM_CODES enabled codes on every
// valid bit once WIDTH bits have been collected; hits produce a registered
// one-cycle pulse, the lowest matching index and a saturating hit counter.
// Optional build macro LUT_SEQ_NONOVERLAP_EN: a match consumes the window, so the
// next match needs WIDTH fresh valid bits.
module lut_seq_match #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned NUM_CODES = 4,
  parameter int unsigned CNT_W     = 8,
  localparam int unsigned IDX_W    = (NUM_CODES > 1) ? $clog2(NUM_CODES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [WIDTH-1:0] cfg_code,
  input  logic             cfg_clr,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr_cnt,
  output logic             match,
  output logic [IDX_W-1:0] match_idx,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             sat,
  output logic             armed
);

  localparam int unsigned FILL_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WIDTH - 1);

  typedef enum logic [0:0] {StFill, StArmed} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     window_q, window_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic [WIDTH-1:0]     code_q [NUM_CODES];
  logic [WIDTH-1:0]     code_d [NUM_CODES];
  logic [NUM_CODES-1:0] en_q, en_d;
  logic                 match_q, match_d;
  logic [IDX_W-1:0]     match_idx_q, match_idx_d;
  logic [CNT_W-1:0]     hit_cnt_q, hit_cnt_d;
  logic                 sat_q, sat_d;

  logic [WIDTH-1:0] win_next;
  logic             hit_any;
  logic [IDX_W-1:0] hit_idx;
  logic             do_cmp;
  logic             cmp_hit;

  assign win_next = {window_q[WIDTH-2:0], in_bit};

  // Priority search over the pre-write table; descending loop leaves the lowest index.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NUM_CODES - 1; i >= 0; i--) begin
      if (en_q[i] && (code_q[i] == win_next)) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Next-state: window/fill FSM, match outputs, counter and table update.
  always_comb begin
    state_d     = state_q;
    window_d    = window_q;
    fill_d      = fill_q;
    match_idx_d = match_idx_q;
    hit_cnt_d   = hit_cnt_q;
    sat_d       = sat_q;
    en_d        = en_q;
    code_d      = code_q;
    do_cmp      = 1'b0;

    if (in_valid) begin
      window_d = win_next;
      if (state_q == StFill) begin
        if (fill_q == FILL_LAST) begin
          // The bit that fills the window is already compared.
          state_d = StArmed;
          fill_d  = '0;
          do_cmp  = 1'b1;
        end else begin
          fill_d = fill_q + 1'b1;
        end
      end else begin
        do_cmp = 1'b1;
      end
    end

    cmp_hit = do_cmp & hit_any;
    match_d = cmp_hit;
    if (cmp_hit) begin
      match_idx_d = hit_idx;
`ifdef LUT_SEQ_NONOVERLAP_EN
      // Matched bits are consumed; refill from scratch.
      state_d = StFill;
      fill_d  = '0;
`endif
    end

    if (clr_cnt) begin
      hit_cnt_d = '0;
      sat_d     = 1'b0;
    end else if (cmp_hit && (hit_cnt_q != CNT_MAX)) begin
      hit_cnt_d = hit_cnt_q + 1'b1;
      sat_d     = sat_q | (hit_cnt_d == CNT_MAX);
    end

    // Clear first so a simultaneous write leaves only that entry enabled.
    if (cfg_clr) begin
      en_d = '0;
    end
    if (cfg_we && (32'(cfg_idx) < NUM_CODES)) begin
      code_d[cfg_idx] = cfg_code;
      en_d[cfg_idx]   = 1'b1;
    end
  end

  // State registers; async reset also wipes the code table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StFill;
      window_q    <= '0;
      fill_q      <= '0;
      en_q        <= '0;
      match_q     <= 1'b0;
      match_idx_q <= '0;
      hit_cnt_q   <= '0;
      sat_q       <= 1'b0;
      for (int i = 0; i < NUM_CODES; i++) begin
        code_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      window_q    <= window_d;
      fill_q      <= fill_d;
      en_q        <= en_d;
      match_q     <= match_d;
      match_idx_q <= match_idx_d;
      hit_cnt_q   <= hit_cnt_d;
      sat_q       <= sat_d;
      for (int i = 0; i < NUM_CODES; i++) begin
        code_q[i] <= code_d[i];
      end
    end
  end

  assign match     = match_q;
  assign match_idx = match_idx_q;
  assign hit_cnt   = hit_cnt_q;
  assign sat       = sat_q;
  assign armed     = (state_q == StArmed);

endmodule

// File: tb/tb_lut_seq_match.sv
// Self-checking bench for lut_seq_match: directed vector table, hand sequences
// for async reset and counter saturation, then random traffic against a model
// that keeps the received bit history in a queue.
module tb_lut_seq_match;

  localparam int W = 4;
  localparam int N = 4;
`ifdef LUT_SEQ_NONOVERLAP_EN
  localparam bit NONOV = 1'b1;
`else
  localparam bit NONOV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_idx = '0;
  logic [3:0] cfg_code = '0;
  logic       cfg_clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       clr_cnt = 1'b0;

  logic       match, sat, armed;
  logic [1:0] match_idx;
  logic [7:0] hit_cnt;
  logic       match2, sat2, armed2;
  logic [1:0] match_idx2;
  logic [1:0] hit_cnt2;

  lut_seq_match dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_code(cfg_code),
    .cfg_clr(cfg_clr), .in_valid(in_valid), .in_bit(in_bit), .clr_cnt(clr_cnt),
    .match(match), .match_idx(match_idx), .hit_cnt(hit_cnt), .sat(sat), .armed(armed)
  );

  lut_seq_match #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_code(cfg_code),
    .cfg_clr(cfg_clr), .in_valid(in_valid), .in_bit(in_bit), .clr_cnt(clr_cnt),
    .match(match2), .match_idx(match_idx2), .hit_cnt(hit_cnt2), .sat(sat2), .armed(armed2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit hist[$];
  int m_code[N];
  bit m_en[N];
  bit e_match;
  int e_idx;
  int e_cnt8, e_cnt2;
  bit e_sat8, e_sat2;
  bit e_armed;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < N; i++) begin
      m_code[i] = 0;
      m_en[i] = 1'b0;
    end
    e_match = 1'b0; e_idx = 0; e_armed = 1'b0;
    e_cnt8 = 0; e_cnt2 = 0; e_sat8 = 1'b0; e_sat2 = 1'b0;
  endfunction

  function automatic void bump(inout int cnt, inout bit s, input int maxv, input bit hit,
                               input bit cc);
    if (cc) begin
      cnt = 0;
      s = 1'b0;
    end else if (hit) begin
      if (cnt < maxv) cnt = cnt + 1;
      if (cnt == maxv) s = 1'b1;
    end
  endfunction

  function automatic void model_step(bit we, int idx, int code, bit clr, bit v, bit b, bit cc);
    bit hit = 1'b0;
    int hidx = 0;
    if (v) begin
      hist.push_back(b);
      if (hist.size() > W) void'(hist.pop_front());
      if (hist.size() == W) begin
        int wv = 0;
        for (int k = 0; k < W; k++) wv = wv * 2 + int'(hist[k]);
        for (int i = 0; i < N; i++) begin
          if (!hit && m_en[i] && m_code[i] == wv) begin
            hit = 1'b1;
            hidx = i;
          end
        end
        if (hit && NONOV) hist.delete();
      end
    end
    e_match = hit;
    if (hit) e_idx = hidx;
    bump(e_cnt8, e_sat8, 255, hit, cc);
    bump(e_cnt2, e_sat2, 3, hit, cc);
    if (clr) for (int i = 0; i < N; i++) m_en[i] = 1'b0;
    if (we && idx < N) begin
      m_code[idx] = code;
      m_en[idx] = 1'b1;
    end
    e_armed = (hist.size() == W);
  endfunction

  function automatic void check_model();
    chk("match", int'(match), int'(e_match));
    chk("match_idx", int'(match_idx), e_idx);
    chk("hit_cnt", int'(hit_cnt), e_cnt8);
    chk("sat", int'(sat), int'(e_sat8));
    chk("armed", int'(armed), int'(e_armed));
    chk("hit_cnt_w2", int'(hit_cnt2), e_cnt2);
    chk("sat_w2", int'(sat2), int'(e_sat2));
  endfunction

  task automatic step(input bit we, input int idx, input int code, input bit clr,
                      input bit v, input bit b, input bit cc);
    @(negedge clk);
    cfg_we = we; cfg_idx = 2'(idx); cfg_code = 4'(code); cfg_clr = clr;
    in_valid = v; in_bit = b; clr_cnt = cc;
    model_step(we, idx, code, clr, v, b, cc);
    @(posedge clk);
    #1;
    check_model();
  endtask

  // Reset asserted away from the clock edge; outputs must clear without an edge.
  task automatic do_reset();
    @(negedge clk);
    cfg_we = 1'b0; cfg_clr = 1'b0; in_valid = 1'b0; in_bit = 1'b0; clr_cnt = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit rst; bit we; int idx; int code; bit clr; bit v; bit b; bit cc;
    bit em; int ei; int ec; bit ea;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit we, int idx, int code, bit clr, bit v, bit b,
                              bit em, int ei, int ec, bit ea);
    vec_t r;
    r.rst = rst; r.we = we; r.idx = idx; r.code = code; r.clr = clr;
    r.v = v; r.b = b; r.cc = 1'b0;
    r.em = em; r.ei = ei; r.ec = ec; r.ea = ea;
    return r;
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    //                rst we idx code clr v b   em ei ec ea
    // Overlapping build 101010 against 1010 / 0101
    vecs.push_back(mk(1, 0, 0, 0,     0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'hA,  0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'h5,  0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,     0, 1, 1,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,     0, 1, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,     0, 1, 1,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,     0, 1, 0,  1, 0, 1, !NONOV));
    vecs.push_back(mk(0, 0, 0, 0,     0, 1, 1,  !NONOV, NONOV ? 0 : 1, NONOV ? 1 : 2, !NONOV));
    vecs.push_back(mk(0, 0, 0, 0,     0, 1, 0,  !NONOV, 0, NONOV ? 1 : 3, !NONOV));
    // Gapped stream
    vecs.push_back(mk(1, 0, 0, 0,     0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'hA,  0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,     0, 1, 1,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,     0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,     0, 1, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,     0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,     0, 1, 1,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,     0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,     0, 1, 0,  1, 0, 1, !NONOV));
    vecs.push_back(mk(0, 0, 0, 0,     0, 0, 0,  0, 0, 1, !NONOV));
    vecs.push_back(mk(0, 0, 0, 0,     0, 0, 0,  0, 0, 1, !NONOV));
    // Duplicates, clear+write, write coincident with compare
    vecs.push_back(mk(1, 0, 0, 0,     0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'hF,  0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 2, 4'hF,  0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,     0, 1, 1,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,     0, 1, 1,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,     0, 1, 1,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,     0, 1, 1,  1, 0, 1, !NONOV));
    vecs.push_back(mk(0, 1, 2, 4'hF,  1, 0, 0,  0, 0, 1, !NONOV));
    vecs.push_back(mk(0, 0, 0, 0,     0, 1, 1,  !NONOV, NONOV ? 0 : 2, NONOV ? 1 : 2, !NONOV));
    vecs.push_back(mk(0, 1, 0, 4'hF,  0, 0, 0,  0, NONOV ? 0 : 2, NONOV ? 1 : 2, !NONOV));
    vecs.push_back(mk(0, 1, 0, 4'h0,  0, 1, 1,  !NONOV, 0, NONOV ? 1 : 3, !NONOV));
    vecs.push_back(mk(0, 0, 0, 0,     0, 1, 1,  !NONOV, NONOV ? 0 : 2, NONOV ? 1 : 4, !NONOV));

    foreach (vecs[n]) begin
      if (vecs[n].rst) do_reset();
      else step(vecs[n].we, vecs[n].idx, vecs[n].code, vecs[n].clr, vecs[n].v, vecs[n].b, 1'b0);
      chk($sformatf("vec%0d.match", n), int'(match), int'(vecs[n].em));
      chk($sformatf("vec%0d.idx", n), int'(match_idx), vecs[n].ei);
      chk($sformatf("vec%0d.cnt", n), int'(hit_cnt), vecs[n].ec);
      chk($sformatf("vec%0d.armed", n), int'(armed), int'(vecs[n].ea));
    end

    // Async reset after 3 of 4 bits: everything clears, table disabled.
    step(1'b1, 0, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    do_reset();
    chk("rst.match", int'(match), 0);
    chk("rst.idx", int'(match_idx), 0);
    chk("rst.cnt", int'(hit_cnt), 0);
    chk("rst.sat", int'(sat), 0);
    chk("rst.armed", int'(armed), 0);
    // Unprogrammed table never matches.
    for (int k = 0; k < 4; k++) step(1'b0, 0, 0, 1'b0, 1'b1, (k % 2) == 0, 1'b0);
    chk("rst.tbl_off", int'(match), 0);
    do_reset();
    step(1'b1, 0, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("refill.3bits", int'(match), 0);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("refill.4bits", int'(match), 1);

    // Saturation on the 2-bit counter, then clear racing a match.
    do_reset();
    step(1'b1, 0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("sat.cnt_w2", int'(hit_cnt2), 3);
    chk("sat.sat_w2", int'(sat2), 1);
    for (int k = 0; k < 3; k++) step(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("clr.match", int'(match), 1);
    chk("clr.cnt_w2", int'(hit_cnt2), 0);
    chk("clr.sat_w2", int'(sat2), 0);
    chk("clr.cnt", int'(hit_cnt), 0);

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 15) == 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
             $urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
             $urandom_range(0, 63) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lut_seq_match.md
Name: lut_seq_match

Overview:
- Registered, parametrised successor of the fixed 4-bit lookup decoder.
- Shifts a serial bit stream into a WIDTH-bit window and compares it each valid cycle against a run-time programmable table of NUM_CODES codes.
- Outputs a one-cycle match pulse, the index of the matching code, and a saturating hit counter.
- Sits after a serial receiver as a pattern/sync-word detector.

Parameters:
- WIDTH, 4, window and code width in bits (>= 2).
- NUM_CODES, 4, number of table entries (>= 1).
- CNT_W, 8, hit-counter width.
- IDX_W, derived, $clog2(NUM_CODES) with a minimum of 1; localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  table write strobe.
- cfg_idx  in  IDX_W  entry to write; values >= NUM_CODES ignored.
- cfg_code  in  WIDTH  code written to entry; entry becomes enabled.
- cfg_clr  in  1  disable all entries (codes kept).
- in_valid  in  1  in_bit is sampled this cycle.
- in_bit  in  1  serial data, newest bit.
- clr_cnt  in  1  synchronous clear of hit_cnt and sat.
- match  out  1  one-cycle pulse: window hit an enabled code.
- match_idx  out  IDX_W  lowest index that matched; held between matches.
- hit_cnt  out  CNT_W  number of matches, saturating.
- sat  out  1  sticky, hit_cnt reached 2^CNT_W-1.
- armed  out  1  window holds WIDTH valid bits (state ARMED).

Behaviour:
- Reset (async, rst_n=0):
  - window=0, fill count=0, state FILL.
  - All entries disabled, codes=0.
  - match=0, match_idx=0, hit_cnt=0, sat=0, armed=0.
- Window shift: on in_valid, window_next = {window[WIDTH-2:0], in_bit}. The newest bit is the LSB; the first-received bit of a code is its MSB.
- FSM states:
  - FILL: count valid bits; no matches. On the WIDTH-th valid bit, compare is performed that same cycle and the state goes to ARMED.
  - ARMED: compare on every in_valid cycle.
- Compare: window_next == code[i] for enabled entries. The lowest i wins.
- Latency: match registered, high in the cycle after the in_valid cycle that completes the pattern. match_idx and the incremented hit_cnt update at the same edge.
- No in_valid means no shift, no compare, and match=0 next cycle.
- Default (overlapping) mode: stays in ARMED after a match, so e.g. 1010 matches twice in 101010.
- Table write:
  - Takes effect at the clock edge.
  - A compare in the same cycle uses the pre-write table (old code and old enable).
  - cfg_clr together with cfg_we: clear applies first, so only the written entry ends up enabled.
- Duplicate codes are allowed; the lowest index is reported.
- Counter:
  - Increments once per match and holds at the all-ones value.
  - sat is set when hit_cnt becomes all-ones and is sticky.
  - clr_cnt has priority over a simultaneous increment: the result is hit_cnt=0, sat=0.
- Reset mid-stream discards partial window contents and returns to FILL. The table is also cleared, so the host must reprogram it.

Optional Feature:
- Macro: LUT_SEQ_NONOVERLAP_EN.
- Defined: after a match, the FSM returns to FILL with fill count=0 and window bits treated as consumed. The next match requires WIDTH fresh valid bits, so 101010 against code 1010 gives exactly one match.
- Undefined: overlapping behaviour as above.

Test Plan:
- Reset, then program idx0=1010 and idx1=0101. Stream 1,0,1,0 with in_valid each cycle -> armed rises with the 4th bit; match=1, match_idx=0, hit_cnt=1 one cycle after the 4th bit.
- Continue the stream with 1,0 (overlap build) -> matches on idx1 (0101), then idx0 (1010); hit_cnt=3. With LUT_SEQ_NONOVERLAP_EN defined, the same 6-bit stream gives hit_cnt=1.
- Gapped stream 1,0,1,0 with in_valid low between bits -> match exactly once, one cycle after the last valid bit. No match in the idle cycles.
- Program idx0=1111 and idx2=1111, then stream 1111 -> match_idx=0. Then cfg_clr plus cfg_we idx2=1111, stream 1 -> match_idx=2. With cfg_we idx0=0000 in the same cycle as the completing bit -> the old code is still used for that compare.
- With CNT_W=2, feed 5 matches -> hit_cnt stays 3 and sat=1. Then clr_cnt coincident with a match -> hit_cnt=0, sat=0.
- Assert rst_n=0 asynchronously mid-pattern (after 3 bits) -> all outputs 0 immediately and the table is disabled. After reprogramming, 3 further bits give no match; a full 4-bit code is required.
